mul_div_unit: RTL

Iterative multiply/divide unit with architectural HI/LO registers, sitting directly downstream of the register file read ports in the execute stage. Consumes the two source operands (rs/rt read data) for MULT/MULTU/DIV/DIVU, runs a 32-iteration shift-add or restoring-divide sequence, and holds results in HI/LO. HI/LO feed MFHI/MFLO results back toward the register-file write port; MTHI/MTLO load them directly.

---
 rtl/mul_div_unit_pkg.sv | 24 ++
 rtl/mul_div_unit_iter.sv | 33 +++
 rtl/mul_div_unit.sv | 119 +++++++++++
 3 files changed

// File: rtl/mul_div_unit_pkg.sv
// rtl/mul_div_unit_pkg.sv - shared constants for the multiply/divide unit
// Operation encodings, FSM state codes and opcode decode helpers.
package mul_div_unit_pkg;

    localparam int MD_WIDTH = 32;

    localparam logic [1:0] MD_MULT  = 2'b00;
    localparam logic [1:0] MD_MULTU = 2'b01;
    localparam logic [1:0] MD_DIV   = 2'b10;
    localparam logic [1:0] MD_DIVU  = 2'b11;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_FIX  = 2'd2;

    function automatic logic op_is_div(input logic [1:0] op);
        return (op == MD_DIV) || (op == MD_DIVU);
    endfunction

    function automatic logic op_is_signed(input logic [1:0] op);
        return (op == MD_MULT) || (op == MD_DIV);
    endfunction

endpackage

// File: rtl/mul_div_unit_iter.sv
// rtl/mul_div_unit_iter.sv - one combinational shift-add or restoring-divide step
// Operates on unsigned magnitudes held in a 2*WIDTH-bit accumulator.
module mul_div_unit_iter
    import mul_div_unit_pkg::*;
#(
    parameter int WIDTH = MD_WIDTH
) (
    input  logic                 is_div,
    input  logic [2*WIDTH-1:0]   acc_in,
    input  logic [WIDTH-1:0]     operand,
    output logic [2*WIDTH-1:0]   acc_out
);

    logic [WIDTH:0] add_sum;
    logic [WIDTH:0] trial;

    // Divide: upper half is the partial remainder, lower half shifts dividend out / quotient in.
    // The shifted remainder needs WIDTH+1 bits, so the trial subtract takes acc_in[2W-1:W-1].
    always_comb begin
        add_sum = {1'b0, acc_in[2*WIDTH-1:WIDTH]} + (acc_in[0] ? {1'b0, operand} : '0);
        trial   = acc_in[2*WIDTH-1:WIDTH-1] - {1'b0, operand};
        if (is_div) begin
            if (trial[WIDTH]) begin
                acc_out = {acc_in[2*WIDTH-2:0], 1'b0};
            end else begin
                acc_out = {trial[WIDTH-1:0], acc_in[WIDTH-2:0], 1'b1};
            end
        end else begin
            acc_out = {add_sum, acc_in[WIDTH-1:1]};
        end
    end

endmodule

// File: rtl/mul_div_unit.sv
// rtl/mul_div_unit.sv - iterative multiply/divide unit with HI/LO registers
// IDLE latches magnitudes, RUN does WIDTH iterations, FIX applies signs and writes HI/LO.
module mul_div_unit
    import mul_div_unit_pkg::*;
#(
    parameter int WIDTH = MD_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] rs_data,
    input  logic [WIDTH-1:0] rt_data,
    input  logic             mthi,
    input  logic             mtlo,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CNT_W = $clog2(WIDTH);

    logic [1:0]         state;
    logic [CNT_W-1:0]   count;
    logic [2*WIDTH-1:0] acc;
    logic [2*WIDTH-1:0] acc_next;
    logic [WIDTH-1:0]   operand;
    logic [WIDTH-1:0]   rs_latched;
    logic               is_div;
    logic               neg_q;
    logic               neg_r;
    logic               div_zero;

    logic               sgn;
    logic [WIDTH-1:0]   rs_mag;
    logic [WIDTH-1:0]   rt_mag;
    logic [2*WIDTH-1:0] product;
    logic [WIDTH-1:0]   quot;
    logic [WIDTH-1:0]   rem;

    always_comb begin
        sgn     = op_is_signed(op);
        rs_mag  = (sgn && rs_data[WIDTH-1]) ? -rs_data : rs_data;
        rt_mag  = (sgn && rt_data[WIDTH-1]) ? -rt_data : rt_data;
        product = neg_q ? -acc : acc;
        quot    = neg_q ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
        rem     = neg_r ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
    end

    mul_div_unit_iter #(.WIDTH(WIDTH)) u_iter (
        .is_div  (is_div),
        .acc_in  (acc),
        .operand (operand),
        .acc_out (acc_next)
    );

    assign busy = (state != ST_IDLE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= ST_IDLE;
            count      <= '0;
            acc        <= '0;
            operand    <= '0;
            rs_latched <= '0;
            is_div     <= 1'b0;
            neg_q      <= 1'b0;
            neg_r      <= 1'b0;
            div_zero   <= 1'b0;
            hi         <= '0;
            lo         <= '0;
            done       <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        operand    <= op_is_div(op) ? rt_mag : rs_mag;
                        acc        <= {{WIDTH{1'b0}}, (op_is_div(op) ? rs_mag : rt_mag)};
                        is_div     <= op_is_div(op);
                        neg_q      <= sgn && (rs_data[WIDTH-1] ^ rt_data[WIDTH-1]);
                        neg_r      <= sgn && rs_data[WIDTH-1];
                        div_zero   <= op_is_div(op) && (rt_data == '0);
                        rs_latched <= rs_data;
                        count      <= '0;
                        state      <= ST_RUN;
                    end else begin
                        if (mthi) hi <= rs_data;
                        if (mtlo) lo <= rs_data;
                    end
                end
                ST_RUN: begin
                    acc   <= acc_next;
                    count <= count + CNT_W'(1);
                    if (count == CNT_W'(WIDTH - 1)) state <= ST_FIX;
                end
                ST_FIX: begin
                    // Zero divisor still runs the full sequence; the result is forced here.
                    if (is_div) begin
                        if (div_zero) begin
                            hi <= rs_latched;
                            lo <= '1;
                        end else begin
                            hi <= rem;
                            lo <= quot;
                        end
                    end else begin
                        {hi, lo} <= product;
                    end
                    state <= ST_IDLE;
                    done  <= 1'b1;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule
